// File: rtl/debounce_scheduler.sv
// debounce_scheduler
//   Debounces CHANNELS asynchronous pins with one shared prescaler and one
//   sequential scan engine. Each debounced press/release is queued in a
//   per-channel pending slot and drained round-robin onto one valid/ready port.
//
// Ports
//   Clk, Rst_n     clock, asynchronous active-low reset
//   Inputs         raw asynchronous pins
//   Enable         low freezes the sample timebase
//   States         debounced level per channel
//   EventValid     event presented
//   EventReady     consumer accepts the presented event
//   EventChannel   channel of the presented event
//   EventPress     1 = press (rising), 0 = release (falling)
//   Overflow       sticky: a pending, unsent event was overwritten
//   OverflowClear  synchronous clear of Overflow
module debounce_scheduler #(
  parameter int unsigned CHANNELS     = 8,
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned STABLE_TICKS = 16
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic [CHANNELS-1:0]         Inputs,
  input  logic                        Enable,
  output logic [CHANNELS-1:0]         States,
  output logic                        EventValid,
  input  logic                        EventReady,
  output logic [$clog2(CHANNELS)-1:0] EventChannel,
  output logic                        EventPress,
  output logic                        Overflow,
  input  logic                        OverflowClear
);

  localparam int unsigned IW = $clog2(CHANNELS);
  localparam int unsigned PW = $clog2(TICK_DIV);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(CHANNELS - 1);
  localparam logic [7:0]    CNT_LAST = 8'(STABLE_TICKS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [PW-1:0]       pre_cnt;
  logic                tick;
  state_t              state;
  logic [IW-1:0]       scan_idx;
  logic [7:0]          cnt_q [CHANNELS];
  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] pol;
  logic [IW-1:0]       rr_ptr;

  // Shared evaluation unit, looking at the channel under the scan index
  logic       cur_sync;
  logic       cur_state;
  logic [7:0] cur_cnt;
  logic       mismatch;
  logic       post;

  // Round-robin selection among pending slots
  logic          grant_ok;
  logic [IW-1:0] grant;
  logic [IW-1:0] rr_next;
  logic          load;
  logic          ovf_set;

  assign tick = Enable && (pre_cnt == PRE_LAST);

  always_comb begin
    cur_sync  = sync2[scan_idx];
    cur_state = States[scan_idx];
    cur_cnt   = cnt_q[scan_idx];
    mismatch  = (state == SCAN) && (cur_sync != cur_state);
    post      = mismatch && (cur_cnt == CNT_LAST);
  end

  // Search starts at rr_ptr (channel after the last grant) and wraps.
  always_comb begin
    int unsigned c;
    c        = 0;
    grant_ok = 1'b0;
    grant    = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      c = 32'(rr_ptr) + k;
      if (c >= CHANNELS) c = c - CHANNELS;
      if (!grant_ok && pend[IW'(c)]) begin
        grant_ok = 1'b1;
        grant    = IW'(c);
      end
    end
  end

  always_comb begin
    rr_next = (grant == IDX_LAST) ? '0 : grant + IW'(1);
    load    = grant_ok && (!EventValid || EventReady);
    // A post onto a slot that is being loaded this same cycle is not an overwrite:
    // the old event leaves via the output register, the new one stays pending.
    ovf_set = post && pend[scan_idx] && !(load && (grant == scan_idx));
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1        <= '0;
      sync2        <= '0;
      pre_cnt      <= '0;
      state        <= IDLE;
      scan_idx     <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      pend         <= '0;
      pol          <= '0;
      rr_ptr       <= '0;
      States       <= '0;
      EventValid   <= 1'b0;
      EventChannel <= '0;
      EventPress   <= 1'b0;
      Overflow     <= 1'b0;
    end else begin
      sync1 <= Inputs;
      sync2 <= sync1;

      if (!Enable || (pre_cnt == PRE_LAST)) pre_cnt <= '0;
      else                                  pre_cnt <= pre_cnt + PW'(1);

      case (state)
        IDLE: begin
          if (tick) begin
            state    <= SCAN;
            scan_idx <= '0;
          end
        end
        SCAN: begin
          if (scan_idx == IDX_LAST) state <= IDLE;
          else                      scan_idx <= scan_idx + IW'(1);
          if (!mismatch) begin
            cnt_q[scan_idx] <= '0;
          end else if (post) begin
            cnt_q[scan_idx]  <= '0;
            States[scan_idx] <= ~cur_state;
          end else begin
            cnt_q[scan_idx] <= cur_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        pend[grant]  <= 1'b0;
        EventValid   <= 1'b1;
        EventChannel <= grant;
        EventPress   <= pol[grant];
        rr_ptr       <= rr_next;
      end else if (EventReady) begin
        EventValid <= 1'b0;
      end

      // Placed after the load so a same-slot post keeps the slot pending.
      if (post) begin
        pend[scan_idx] <= 1'b1;
        pol[scan_idx]  <= ~cur_state;
      end

      if (ovf_set)            Overflow <= 1'b1;
      else if (OverflowClear) Overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_debounce_scheduler.sv
module tb_debounce_scheduler;

  localparam int unsigned CH = 4;
  localparam int unsigned TD = 8;
  localparam int unsigned ST = 3;

  logic          Clk;
  logic          Rst_n;
  logic [CH-1:0] Inputs;
  logic          Enable;
  logic [CH-1:0] States;
  logic          EventValid;
  logic          EventReady;
  logic [1:0]    EventChannel;
  logic          EventPress;
  logic          Overflow;
  logic          OverflowClear;

  int n_tests = 0;
  int n_fail  = 0;

  debounce_scheduler #(
    .CHANNELS(CH),
    .TICK_DIV(TD),
    .STABLE_TICKS(ST)
  ) dut (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .Inputs(Inputs),
    .Enable(Enable),
    .States(States),
    .EventValid(EventValid),
    .EventReady(EventReady),
    .EventChannel(EventChannel),
    .EventPress(EventPress),
    .Overflow(Overflow),
    .OverflowClear(OverflowClear)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model: samples seen two clocks late, a tick every TD
  // consecutive enabled clocks, one channel per clock after each tick,
  // toggle after ST consecutive mismatching samples.
  typedef struct {
    int   ch;
    logic press;
  } ev_t;

  ev_t           exp_q[$];
  int            log_q[$];
  logic [CH-1:0] h1, h2, m_states;
  int            m_streak[CH];
  int            m_scan;
  int unsigned   m_run;

  always @(posedge Clk or negedge Rst_n) begin
    logic [1:0] ci;
    if (!Rst_n) begin
      h1 = '0; h2 = '0; m_states = '0;
      for (int i = 0; i < CH; i++) m_streak[i] = 0;
      m_scan = -1;
      m_run  = 0;
      exp_q.delete();
    end else begin
      if (m_scan >= 0) begin
        ci = 2'(m_scan);
        if (h2[ci] == m_states[ci]) m_streak[ci] = 0;
        else begin
          m_streak[ci]++;
          if (m_streak[ci] == ST) begin
            m_states[ci] = ~m_states[ci];
            m_streak[ci] = 0;
            exp_q.push_back('{m_scan, m_states[ci]});
          end
        end
        m_scan = (m_scan == CH - 1) ? -1 : m_scan + 1;
      end
      h2 = h1;
      h1 = Inputs;
      if (Enable) begin
        if (m_run % TD == TD - 1) m_scan = 0;
        m_run++;
      end else begin
        m_run = 0;
      end
    end
  end

  // Per-cycle monitor: debounced levels, delivered events, handshake hold.
  logic       prev_valid;
  logic [1:0] prev_ch;
  logic       prev_press;

  always @(negedge Clk) begin
    int  idx;
    logic found;
    if (!Rst_n) begin
      prev_valid = 1'b0;
    end else begin
      check("states", 32'(States), 32'(m_states));
      if (prev_valid) begin
        if (EventReady) begin
          idx = -1;
          for (int i = 0; i < exp_q.size(); i++)
            if (idx < 0 && exp_q[i].ch == int'(prev_ch)) idx = i;
          found = (idx >= 0);
          check("event_expected", 32'(found), 32'd1);
          if (found) begin
            check("event_press", 32'(prev_press), 32'(exp_q[idx].press));
            exp_q.delete(idx);
          end
          log_q.push_back(int'(prev_ch));
        end else begin
          check("hold_valid", 32'(EventValid), 32'd1);
          check("hold_channel", 32'(EventChannel), 32'(prev_ch));
          check("hold_press", 32'(EventPress), 32'(prev_press));
        end
      end
      prev_valid = EventValid;
      prev_ch    = EventChannel;
      prev_press = EventPress;
    end
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge Clk);
    #1;
  endtask

  initial begin
    logic       saw;
    int         n;
    logic [1:0] j;

    Rst_n = 1'b0; Inputs = '0; Enable = 1'b0; EventReady = 1'b1; OverflowClear = 1'b0;
    nclk(3);
    check("rst_states", 32'(States), 32'd0);
    check("rst_valid", 32'(EventValid), 32'd0);
    check("rst_channel", 32'(EventChannel), 32'd0);
    check("rst_press", 32'(EventPress), 32'd0);
    check("rst_overflow", 32'(Overflow), 32'd0);

    // Idle after reset
    Rst_n = 1'b1; Enable = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 200; i++) begin nclk(1); if (EventValid) saw = 1'b1; end
    check("idle_no_event", 32'(saw), 32'd0);
    check("idle_states", 32'(States), 32'd0);
    check("idle_overflow", 32'(Overflow), 32'd0);

    // Single press on channel 2
    Inputs[2] = 1'b1;
    n = 0;
    while (!States[2] && n < 200) begin nclk(1); n++; end
    check("press_state", 32'(States[2]), 32'd1);
    check("press_no_early_valid", 32'(EventValid), 32'd0);
    nclk(1);
    check("press_valid", 32'(EventValid), 32'd1);
    check("press_channel", 32'(EventChannel), 32'd2);
    check("press_polarity", 32'(EventPress), 32'd1);
    nclk(1);
    check("press_single", 32'(EventValid), 32'd0);

    // 12-clock glitch on channel 1
    Inputs[1] = 1'b1;
    nclk(12);
    Inputs[1] = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 60; i++) begin nclk(1); if (EventValid) saw = 1'b1; end
    check("glitch_state", 32'(States[1]), 32'd0);
    check("glitch_no_event", 32'(saw), 32'd0);

    // Round-robin under backpressure
    EventReady = 1'b0;
    Inputs[0] = 1'b1; Inputs[3] = 1'b1;
    nclk(100);
    check("rr_states", 32'(States), 32'hD);
    check("rr_valid", 32'(EventValid), 32'd1);
    check("rr_first_channel", 32'(EventChannel), 32'd0);
    check("rr_first_press", 32'(EventPress), 32'd1);
    EventReady = 1'b1;
    nclk(1);
    check("rr_second_valid", 32'(EventValid), 32'd1);
    check("rr_second_channel", 32'(EventChannel), 32'd3);
    nclk(1);
    check("rr_drained", 32'(EventValid), 32'd0);

    // Overflow: channel 0 release blocks the port, channel 1 press+release
    EventReady = 1'b0;
    Inputs[0] = 1'b0;
    n = 0;
    while (States[0] && n < 200) begin nclk(1); n++; end
    nclk(1);
    check("ovf_block_valid", 32'(EventValid), 32'd1);
    check("ovf_block_channel", 32'(EventChannel), 32'd0);
    check("ovf_block_press", 32'(EventPress), 32'd0);
    Inputs[1] = 1'b1;
    n = 0;
    while (!States[1] && n < 200) begin nclk(1); n++; end
    check("ovf_press_state", 32'(States[1]), 32'd1);
    Inputs[1] = 1'b0;
    n = 0;
    while (States[1] && n < 200) begin nclk(1); n++; end
    check("ovf_release_state", 32'(States[1]), 32'd0);
    nclk(1);
    check("ovf_set", 32'(Overflow), 32'd1);
    // The pending press was overwritten: only the release remains deliverable.
    for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].ch == 1) exp_q.delete(i);
    exp_q.push_back('{1, 1'b0});
    EventReady = 1'b1;
    nclk(1);
    check("ovf_ch1_valid", 32'(EventValid), 32'd1);
    check("ovf_ch1_channel", 32'(EventChannel), 32'd1);
    check("ovf_ch1_press", 32'(EventPress), 32'd0);
    nclk(1);
    check("ovf_ch1_once", 32'(EventValid), 32'd0);
    check("ovf_sticky", 32'(Overflow), 32'd1);
    OverflowClear = 1'b1;
    nclk(1);
    OverflowClear = 1'b0;
    check("ovf_cleared", 32'(Overflow), 32'd0);

    // Asynchronous reset in the middle of a scan
    Inputs = 4'hF;
    nclk(30);
    n = 0;
    while (m_scan != 1 && n < 50) begin nclk(1); n++; end
    check("scan_reached", 32'(m_scan), 32'd1);
    #2 Rst_n = 1'b0;
    #1;
    check("arst_states", 32'(States), 32'd0);
    check("arst_valid", 32'(EventValid), 32'd0);
    check("arst_channel", 32'(EventChannel), 32'd0);
    check("arst_press", 32'(EventPress), 32'd0);
    check("arst_overflow", 32'(Overflow), 32'd0);
    nclk(2);
    Rst_n = 1'b1;
    log_q.delete();
    nclk(80);
    check("arst_recover_states", 32'(States), 32'hF);
    check("arst_event_count", 32'(log_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < log_q.size(); i++)
      check("arst_event_order", 32'(log_q[i]), 32'(i));

    // Enable freeze
    Enable = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (i % 5 == 0) Inputs[2] = ~Inputs[2];
      nclk(1);
      if (EventValid) saw = 1'b1;
    end
    check("freeze_states", 32'(States), 32'hF);
    check("freeze_no_event", 32'(saw), 32'd0);
    Inputs[2] = 1'b0;
    Enable = 1'b1;
    n = 0;
    while (States[2] && n < 200) begin nclk(1); n++; end
    check("resume_state", 32'(States[2]), 32'd0);
    nclk(1);
    check("resume_valid", 32'(EventValid), 32'd1);
    check("resume_channel", 32'(EventChannel), 32'd2);
    check("resume_press", 32'(EventPress), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      nclk(1);
      EventReady = ($urandom_range(0, 3) != 0);
      Enable     = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 15) == 0) begin
        j = 2'($urandom_range(0, 3));
        Inputs[j] = ~Inputs[j];
      end
    end
    Enable = 1'b1;
    EventReady = 1'b1;
    nclk(100);
    check("random_drained", 32'(exp_q.size()), 32'd0);
    check("random_valid_idle", 32'(EventValid), 32'd0);
    check("random_no_overflow", 32'(Overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
